commit_sequencer: RTL

Buffers per-instruction retirement records from the core wrapper and replays them to the ISA checker as ordered, back-pressured beats. A trapping record emits an exception-event beat before its commit beat. The block also maintains liveness and overflow monitors that the formal top asserts on. It sits between the core's commit/memory/trap outputs and the checker's instCommit/event/mem inputs, so the checker can stall without losing records.

---
 rtl/commit_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/commit_sequencer.sv
// Retirement-record buffer between the core commit port and the ISA checker.
// Replays records as back-pressured event/commit beats and tracks overflow and liveness.
module commit_sequencer #(
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_mem_read_valid,
  input  logic                     in_mem_write_valid,
  input  logic [31:0]              in_mem_read_addr,
  input  logic [31:0]              in_mem_read_data,
  input  logic [31:0]              in_mem_write_addr,
  input  logic [31:0]              in_mem_write_data,
  input  logic                     in_trap,
  input  logic [31:0]              in_trap_cause,

  input  logic                     out_ready,
  output logic                     out_commit_valid,
  output logic [31:0]              out_commit_pc,
  output logic [31:0]              out_commit_inst,
  output logic                     out_mem_read_valid,
  output logic                     out_mem_write_valid,
  output logic [31:0]              out_mem_read_addr,
  output logic [31:0]              out_mem_read_data,
  output logic [31:0]              out_mem_write_addr,
  output logic [31:0]              out_mem_write_data,
  output logic                     out_event_valid,
  output logic [31:0]              out_event_cause,
  output logic [31:0]              out_event_pc,
  output logic [31:0]              out_event_inst,

  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     wdog_timeout
);

  // state    | meaning
  // ---------+---------------------------------------------------------
  // S_IDLE   | output stage empty, no beat presented
  // S_EVENT  | exception-event beat of the held (trapping) record
  // S_COMMIT | commit beat of the held record

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int WCW = $clog2(WDOG_CYCLES + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        trap;
    logic [31:0] trap_cause;
  } rec_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVENT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  rec_t            rec_q, rec_d;
  rec_t            in_rec;
  rec_t            head_rec;
  rec_t            fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [WCW-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic            overflow_q, wdog_timeout_q;
  logic            full, empty;
  logic            push_ok, push_fifo, pop, bypass;
  logic            transfer, free, commit_xfer;

  always_comb begin
    in_rec                 = '0;
    in_rec.pc              = in_pc;
    in_rec.inst            = in_inst;
    in_rec.mem_read_valid  = in_mem_read_valid;
    in_rec.mem_write_valid = in_mem_write_valid;
    in_rec.mem_read_addr   = in_mem_read_addr;
    in_rec.mem_read_data   = in_mem_read_data;
    in_rec.mem_write_addr  = in_mem_write_addr;
    in_rec.mem_write_data  = in_mem_write_data;
    in_rec.trap            = in_trap;
    in_rec.trap_cause      = in_trap_cause;
  end

  assign head_rec = fifo_mem[rd_ptr_q];
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push_ok  = in_valid && !full;

  assign transfer    = (state_q != S_IDLE) && out_ready;
  assign free        = (state_q == S_IDLE) || transfer;
  assign commit_xfer = (state_q == S_COMMIT) && out_ready;

  // Next-state / output-stage load. A free EVENT stage always means its beat
  // just transferred, so the same record moves on to its commit beat.
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (free) begin
      if (state_q == S_EVENT) begin
        state_d = S_COMMIT;
      end else if (!empty) begin
        pop     = 1'b1;
        rec_d   = head_rec;
        state_d = head_rec.trap ? S_EVENT : S_COMMIT;
      end else if (push_ok) begin
        bypass  = 1'b1;
        rec_d   = in_rec;
        state_d = in_trap ? S_EVENT : S_COMMIT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  assign push_fifo = push_ok && !bypass;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (commit_xfer) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q != WCW'(WDOG_CYCLES)) begin
      wdog_cnt_d = wdog_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rec_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      wdog_cnt_q <= wdog_cnt_d;
      if (push_fifo) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_fifo && !pop)      level_q <= level_q + LW'(1);
      else if (!push_fifo && pop) level_q <= level_q - LW'(1);
      if (in_valid && full) overflow_q <= 1'b1;
      if (wdog_cnt_d == WCW'(WDOG_CYCLES)) wdog_timeout_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push_fifo) begin
      fifo_mem[wr_ptr_q] <= in_rec;
    end
  end

  assign in_ready     = !full;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign wdog_timeout = wdog_timeout_q;

  assign out_commit_valid    = (state_q == S_COMMIT);
  assign out_event_valid     = (state_q == S_EVENT);
  assign out_commit_pc       = rec_q.pc;
  assign out_commit_inst     = rec_q.inst;
  // A trapping instruction never performed its access.
  assign out_mem_read_valid  = out_commit_valid && rec_q.mem_read_valid && !rec_q.trap;
  assign out_mem_write_valid = out_commit_valid && rec_q.mem_write_valid && !rec_q.trap;
  assign out_mem_read_addr   = rec_q.mem_read_addr;
  assign out_mem_read_data   = rec_q.mem_read_data;
  assign out_mem_write_addr  = rec_q.mem_write_addr;
  assign out_mem_write_data  = rec_q.mem_write_data;
  assign out_event_cause     = rec_q.trap_cause;
  assign out_event_pc        = rec_q.pc;
  assign out_event_inst      = rec_q.inst;

endmodule
